// File: rtl/mem_fill_arbiter_if.sv
// Memory-side bus of the fill arbiter: request strobe/address/write data out, read data/valid back.
interface mem_fill_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              mem_en;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_data_in;
    logic [ADDR_W-1:0] memory_data;
    logic              memory_data_valid;

    modport master (
        output mem_en, mem_write, mem_addr, mem_data_in,
        input  memory_data, memory_data_valid
    );

    modport slave (
        input  mem_en, mem_write, mem_addr, mem_data_in,
        output memory_data, memory_data_valid
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined memory between I-cache fills, D-cache fills and D-cache write-through stores.
// Optional fill performance counters are enabled by defining MEM_FILL_PERF_EN.
module mem_fill_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int BLK_WORDS = 8,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_miss,
    input  logic [ADDR_W-1:0] I_miss_addr,
    input  logic              D_miss,
    input  logic [ADDR_W-1:0] D_miss_addr,
    input  logic              D_wr_req,
    input  logic [ADDR_W-1:0] D_wr_addr,
    input  logic [ADDR_W-1:0] D_wr_data,
    mem_fill_arbiter_if.master mem,
    output logic              fsm_busy,
    output logic              stall,
    output logic              I_write_data_array,
    output logic              D_write_data_array,
    output logic              I_write_tag_array,
    output logic              D_write_tag_array,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [CNT_W-1:0]  fill_word,
    output logic [ADDR_W-1:0] fill_data,
    output logic [15:0]       I_fill_count,
    output logic [15:0]       D_fill_count
);
    // Byte offset within a block of 16-bit words.
    localparam int OFF_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              owner_r;       // 0 = I-cache, 1 = D-cache
    logic [ADDR_W-1:0] fill_addr_r;
    logic [CNT_W:0]    iss_cnt_r;     // extra MSB marks all words issued
    logic [CNT_W-1:0]  ret_cnt_r;
    logic              start_s;
    logic              issue_s;
    logic              last_ret_s;
    logic              unused_s;

    assign start_s    = (state_r == ST_IDLE) && (I_miss || D_miss);
    assign issue_s    = (state_r == ST_FILL) && !iss_cnt_r[CNT_W];
    assign last_ret_s = (state_r == ST_FILL) && mem.memory_data_valid &&
                        (ret_cnt_r == CNT_W'(BLK_WORDS - 1));
    assign unused_s   = ^{I_miss_addr[OFF_W-1:0], D_miss_addr[OFF_W-1:0]};

    assign fsm_busy  = (state_r != ST_IDLE);
    assign stall     = fsm_busy | I_miss | D_miss;
    assign fill_addr = fill_addr_r;
    assign fill_word = ret_cnt_r;
    assign fill_data = mem.memory_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: misses win over stores, I-cache wins over D-cache.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (I_miss || D_miss) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (last_ret_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Fill owner, block base and issue/return counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= 1'b0;
            fill_addr_r <= {ADDR_W{1'b0}};
            iss_cnt_r   <= {(CNT_W+1){1'b0}};
            ret_cnt_r   <= {CNT_W{1'b0}};
        end else if (start_s) begin
            owner_r     <= !I_miss;
            fill_addr_r <= I_miss ? {I_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                                  : {D_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            iss_cnt_r   <= {(CNT_W+1){1'b0}};
            ret_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (issue_s) begin
                iss_cnt_r <= iss_cnt_r + {{CNT_W{1'b0}}, 1'b1};
            end
            if ((state_r == ST_FILL) && mem.memory_data_valid) begin
                ret_cnt_r <= ret_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Memory requests and cache array write strobes.
    always_comb begin
        mem.mem_en         = 1'b0;
        mem.mem_write      = 1'b0;
        mem.mem_addr       = {ADDR_W{1'b0}};
        mem.mem_data_in    = {ADDR_W{1'b0}};
        I_write_data_array = 1'b0;
        D_write_data_array = 1'b0;
        I_write_tag_array  = 1'b0;
        D_write_tag_array  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!I_miss && !D_miss && D_wr_req) begin
                    mem.mem_en      = 1'b1;
                    mem.mem_write   = 1'b1;
                    mem.mem_addr    = D_wr_addr;
                    mem.mem_data_in = D_wr_data;
                end else begin
                    mem.mem_en = 1'b0;
                end
            end
            ST_FILL: begin
                if (issue_s) begin
                    mem.mem_en   = 1'b1;
                    mem.mem_addr = fill_addr_r | ADDR_W'({iss_cnt_r[CNT_W-1:0], 1'b0});
                end else begin
                    mem.mem_en = 1'b0;
                end
                if (mem.memory_data_valid) begin
                    I_write_data_array = !owner_r;
                    D_write_data_array = owner_r;
                    I_write_tag_array  = last_ret_s && !owner_r;
                    D_write_tag_array  = last_ret_s && owner_r;
                end else begin
                    I_write_data_array = 1'b0;
                end
            end
            ST_DONE: mem.mem_en = 1'b0;
            default: mem.mem_en = 1'b0;
        endcase
    end

`ifdef MEM_FILL_PERF_EN
    logic [15:0] i_cnt_r;
    logic [15:0] d_cnt_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Completed-fill counters, one per owner, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt_r <= 16'h0000;
            d_cnt_r <= 16'h0000;
        end else begin
            if (I_write_tag_array) begin
                i_cnt_r <= sat_inc(i_cnt_r);
            end
            if (D_write_tag_array) begin
                d_cnt_r <= sat_inc(d_cnt_r);
            end
        end
    end

    assign I_fill_count = i_cnt_r;
    assign D_fill_count = d_cnt_r;
`else
    assign I_fill_count = 16'h0000;
    assign D_fill_count = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: schedule-based reference model plus a 4-cycle memory.
module tb_mem_fill_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        I_miss = 1'b0, D_miss = 1'b0, D_wr_req = 1'b0;
    logic [15:0] I_miss_addr = 16'h0, D_miss_addr = 16'h0, D_wr_addr = 16'h0, D_wr_data = 16'h0;
    logic        fsm_busy, stall;
    logic        I_write_data_array, D_write_data_array, I_write_tag_array, D_write_tag_array;
    logic [15:0] fill_addr, fill_data, I_fill_count, D_fill_count;
    logic [2:0]  fill_word;

    mem_fill_arbiter_if #(.ADDR_W(16)) bus ();

    mem_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .I_miss(I_miss), .I_miss_addr(I_miss_addr),
        .D_miss(D_miss), .D_miss_addr(D_miss_addr),
        .D_wr_req(D_wr_req), .D_wr_addr(D_wr_addr), .D_wr_data(D_wr_data),
        .mem(bus.master),
        .fsm_busy(fsm_busy), .stall(stall),
        .I_write_data_array(I_write_data_array), .D_write_data_array(D_write_data_array),
        .I_write_tag_array(I_write_tag_array), .D_write_tag_array(D_write_tag_array),
        .fill_addr(fill_addr), .fill_word(fill_word), .fill_data(fill_data),
        .I_fill_count(I_fill_count), .D_fill_count(D_fill_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Reference model: a fill is a fixed schedule counted from the first FILL cycle (rel 0).
    bit          m_active = 1'b0;
    int          m_rel = 0;
    bit          m_owner = 1'b0;
    logic [15:0] m_base = 16'h0;
    int          m_icnt = 0, m_dcnt = 0;

    // Cache-side requests (held until served) and the memory read pipeline.
    bit          i_req = 1'b0, d_req = 1'b0, w_req = 1'b0;
    logic [15:0] i_addr = 16'h0, d_addr = 16'h0, w_addr = 16'h0, w_data = 16'h0;
    bit          pipe_v[4];
    logic [15:0] pipe_a[4];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int c);
`ifdef MEM_FILL_PERF_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return 16'(c * 0);
`endif
    endfunction

    task automatic step();
        bit          e_en, e_wr, e_iw, e_dw, e_it, e_dt, e_busy;
        logic [15:0] e_addr, e_din;
        int          e_word;
        @(negedge clk);
        cyc++;
        I_miss = i_req;  I_miss_addr = i_addr;
        D_miss = d_req;  D_miss_addr = d_addr;
        D_wr_req = w_req; D_wr_addr = w_addr; D_wr_data = w_data;
        if (pipe_v[3]) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = pipe_a[3] ^ 16'h5A3C;
        end else if ((!m_active || m_rel == 12) && $urandom_range(0, 3) == 0) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = 16'($urandom);
        end else begin
            bus.memory_data_valid = 1'b0;
            bus.memory_data       = 16'($urandom);
        end
        #1;
        {e_en, e_wr, e_iw, e_dw, e_it, e_dt, e_busy} = 7'd0;
        e_addr = 16'h0; e_din = 16'h0; e_word = 0;
        if (!m_active) begin
            if (!I_miss && !D_miss && D_wr_req) begin
                e_en = 1'b1; e_wr = 1'b1; e_addr = D_wr_addr; e_din = D_wr_data;
            end
        end else begin
            e_busy = 1'b1;
            if (m_rel < 8) begin
                e_en = 1'b1; e_addr = m_base + 16'(2 * m_rel);
            end
            if (m_rel >= 4 && m_rel <= 11) begin
                if (m_owner) e_dw = 1'b1; else e_iw = 1'b1;
                e_word = m_rel - 4;
            end
            if (m_rel == 11) begin
                if (m_owner) e_dt = 1'b1; else e_it = 1'b1;
            end
        end
        chk("mem_en", {15'd0, bus.mem_en}, {15'd0, e_en});
        if (e_en) begin
            chk("mem_write", {15'd0, bus.mem_write}, {15'd0, e_wr});
            chk("mem_addr", bus.mem_addr, e_addr);
        end
        if (e_wr) chk("mem_data_in", bus.mem_data_in, e_din);
        chk("fsm_busy", {15'd0, fsm_busy}, {15'd0, e_busy});
        chk("stall", {15'd0, stall}, {15'd0, e_busy | I_miss | D_miss});
        chk("I_wda", {15'd0, I_write_data_array}, {15'd0, e_iw});
        chk("D_wda", {15'd0, D_write_data_array}, {15'd0, e_dw});
        chk("I_tag", {15'd0, I_write_tag_array}, {15'd0, e_it});
        chk("D_tag", {15'd0, D_write_tag_array}, {15'd0, e_dt});
        if (e_iw || e_dw) chk("fill_word", {13'd0, fill_word}, 16'(e_word));
        chk("fill_data", fill_data, bus.memory_data);
        if (e_busy) chk("fill_addr", fill_addr, m_base);
        chk("I_fill_count", I_fill_count, exp_cnt(m_icnt));
        chk("D_fill_count", D_fill_count, exp_cnt(m_dcnt));
        for (int k = 3; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_a[k] = pipe_a[k-1];
        end
        pipe_v[0] = bus.mem_en && !bus.mem_write;
        pipe_a[0] = bus.mem_addr;
        if (e_it) begin i_req = 1'b0; m_icnt++; end
        if (e_dt) begin d_req = 1'b0; m_dcnt++; end
        if (e_wr) w_req = 1'b0;
        if (!m_active) begin
            if (I_miss || D_miss) begin
                m_active = 1'b1;
                m_rel    = 0;
                m_owner  = !I_miss;
                m_base   = (I_miss ? I_miss_addr : D_miss_addr) & 16'hFFF0;
            end
        end else begin
            m_rel++;
            if (m_rel > 12) m_active = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_req = 1'b0; d_req = 1'b0; w_req = 1'b0;
        I_miss = 1'b0; D_miss = 1'b0; D_wr_req = 1'b0;
        bus.memory_data_valid = 1'b0; bus.memory_data = 16'h0;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_en", {15'd0, bus.mem_en}, 16'd0);
        chk("rst_mem_write", {15'd0, bus.mem_write}, 16'd0);
        chk("rst_busy", {15'd0, fsm_busy}, 16'd0);
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_strobes", {12'd0, I_write_data_array, D_write_data_array,
                            I_write_tag_array, D_write_tag_array}, 16'd0);
        chk("rst_fill_addr", fill_addr, 16'h0000);
        chk("rst_fill_word", {13'd0, fill_word}, 16'd0);
        chk("rst_counts", I_fill_count | D_fill_count, 16'h0000);
        m_active = 1'b0; m_rel = 0; m_icnt = 0; m_dcnt = 0;
        for (int k = 0; k < 4; k++) pipe_v[k] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic settle();
        int n = 0;
        do begin
            step();
            n++;
        end while ((i_req || d_req || w_req || m_active) && n < 300);
        if (n >= 300) begin
            n_total++;
            $display("FAIL settle_timeout cycle %0d: requests still pending after %0d cycles", cyc, n);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin pipe_v[k] = 1'b0; pipe_a[k] = 16'h0; end
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0;
        #2;
        do_reset();

        // I-cache miss at 16'h1236: literal schedule pins.
        i_req = 1'b1; i_addr = 16'h1236;
        for (int r = 0; r <= 14; r++) begin
            step();
            case (r)
                1:  begin chk("t1_en1", {15'd0, bus.mem_en}, 16'd1); chk("t1_addr1", bus.mem_addr, 16'h1230); end
                5:  begin chk("t1_wda5", {15'd0, I_write_data_array}, 16'd1); chk("t1_word5", {13'd0, fill_word}, 16'd0); end
                8:  chk("t1_addr8", bus.mem_addr, 16'h123E);
                12: chk("t1_tag12", {15'd0, I_write_tag_array}, 16'd1);
                13: chk("t1_busy13", {15'd0, fsm_busy}, 16'd1);
                14: chk("t1_busy14", {15'd0, fsm_busy}, 16'd0);
                default: ;
            endcase
        end

        // Simultaneous I and D misses: I first, D immediately after.
        i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; d_addr = 16'h8010;
        for (int r = 0; r <= 28; r++) begin
            step();
            case (r)
                1:  chk("t2_i_addr", bus.mem_addr, 16'h0040);
                15: begin chk("t2_d_en", {15'd0, bus.mem_en}, 16'd1); chk("t2_d_addr0", bus.mem_addr, 16'h8010); end
                22: chk("t2_d_addr7", bus.mem_addr, 16'h801E);
                26: chk("t2_d_tag", {15'd0, D_write_tag_array}, 16'd1);
                default: ;
            endcase
        end

        // Write-through store in IDLE.
        w_req = 1'b1; w_addr = 16'h2002; w_data = 16'hBEEF;
        step();
        chk("t3_en", {15'd0, bus.mem_en}, 16'd1);
        chk("t3_write", {15'd0, bus.mem_write}, 16'd1);
        chk("t3_addr", bus.mem_addr, 16'h2002);
        chk("t3_data", bus.mem_data_in, 16'hBEEF);
        chk("t3_busy", {15'd0, fsm_busy}, 16'd0);

        // Store presented during a fill waits until IDLE.
        i_req = 1'b1; i_addr = 16'h3000;
        for (int r = 0; r <= 15; r++) begin
            if (r == 3) begin w_req = 1'b1; w_addr = 16'h3004; w_data = 16'h1234; end
            step();
            if (r == 8) chk("t4_stall", {15'd0, stall}, 16'd1);
            if (r == 14) begin
                chk("t4_write", {15'd0, bus.mem_write}, 16'd1);
                chk("t4_addr", bus.mem_addr, 16'h3004);
            end
        end

        // Reset after the 3rd returned word, then restart.
        i_req = 1'b1; i_addr = 16'h7770;
        for (int n = 0; n < 40 && !(m_active && m_rel == 7); n++) step();
        do_reset();
        i_req = 1'b1; i_addr = 16'h4448;
        for (int r = 0; r <= 5; r++) begin
            step();
            if (r == 5) begin
                chk("t5_wda", {15'd0, I_write_data_array}, 16'd1);
                chk("t5_word", {13'd0, fill_word}, 16'd0);
            end
        end
        settle();

        // Fill counters: 3 I fills and 2 D fills since reset.
        for (int k = 0; k < 2; k++) begin
            i_req = 1'b1; i_addr = 16'(16'h5000 + k * 16'h0100); settle();
            d_req = 1'b1; d_addr = 16'(16'h9000 + k * 16'h0100); settle();
        end
        step();
`ifdef MEM_FILL_PERF_EN
        chk("t6_icnt", I_fill_count, 16'd3);
        chk("t6_dcnt", D_fill_count, 16'd2);
`else
        chk("t6_icnt", I_fill_count, 16'd0);
        chk("t6_dcnt", D_fill_count, 16'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if (!i_req && $urandom_range(0, 15) == 0) begin i_req = 1'b1; i_addr = 16'($urandom); end
            if (!d_req && $urandom_range(0, 15) == 0) begin d_req = 1'b1; d_addr = 16'($urandom); end
            if (!w_req && $urandom_range(0, 5) == 0) begin
                w_req = 1'b1; w_addr = 16'($urandom); w_data = 16'($urandom);
            end
            step();
        end
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
